// File: rtl/spi_cmd_pkg.sv
// Shared types, command codes and payload-length lookup for the SPI command decoder.
package spi_cmd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StPayload,
        StCheck
    } state_e;

    localparam logic [7:0] CmdFreq         = 8'h01;
    localparam logic [7:0] CmdPhase        = 8'h02;
    localparam logic [7:0] CmdWave         = 8'h03;
    localparam logic [7:0] CmdLed          = 8'h04;
    localparam logic [7:0] SyncByteDefault = 8'hA5;

    // Zero marks an unknown command.
    function automatic logic [2:0] cmd_len(input logic [7:0] cmd);
        case (cmd)
            CmdFreq:  return 3'd4;
            CmdPhase: return 3'd2;
            CmdWave:  return 3'd1;
            CmdLed:   return 3'd1;
            default:  return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Byte-stream input and decoded register outputs of the SPI command decoder.
interface spi_cmd_decoder_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        spi_ss;
    logic [31:0] freq_word;
    logic [15:0] phase_word;
    logic [1:0]  wave_sel;
    logic [3:0]  led_groups;
    logic        cfg_update;
    logic        frame_err;
    logic [7:0]  err_cnt;

    modport master (
        output byte_valid, byte_data, spi_ss,
        input  freq_word, phase_word, wave_sel, led_groups, cfg_update, frame_err, err_cnt
    );

    modport slave (
        input  byte_valid, byte_data, spi_ss,
        output freq_word, phase_word, wave_sel, led_groups, cfg_update, frame_err, err_cnt
    );
endinterface

// File: rtl/spi_cmd_timeout.sv
// Inactivity counter: counts while enabled, clears on request, strobes on the last count.
module spi_cmd_timeout #(
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYC - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expire_o = en_i && !clr_i && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_cmd_decoder.sv
// Parses SYNC/CMD/payload[/CHK] frames into DDS and LED registers, committing atomically.
// Define CMD_CHECKSUM_EN to require and verify the trailing XOR checksum byte.
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter logic [7:0]  SYNC_BYTE   = SyncByteDefault
) (
    input logic              clk,
    input logic              rst,
    spi_cmd_decoder_if.slave bus_io
);

    state_e      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [2:0]  rem_q, rem_d;
    logic [31:0] stage_q, stage_d, stage_shift;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]  xor_q, xor_d;
`endif
    logic [31:0] freq_q, freq_d;
    logic [15:0] phase_q, phase_d;
    logic [1:0]  wave_q, wave_d;
    logic [3:0]  led_q, led_d;
    logic        cfg_q, cfg_d;
    logic        ferr_q, ferr_d;
    logic [7:0]  errc_q, errc_d;
    logic        busy, expire, tmo_clr, commit;
    logic [31:0] commit_val;

    assign busy    = (state_q != StIdle);
    assign tmo_clr = bus_io.byte_valid || !busy;

    spi_cmd_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (tmo_clr),
        .en_i    (busy),
        .expire_o(expire)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        rem_d      = rem_q;
        stage_d    = stage_q;
`ifdef CMD_CHECKSUM_EN
        xor_d      = xor_q;
`endif
        freq_d     = freq_q;
        phase_d    = phase_q;
        wave_d     = wave_q;
        led_d      = led_q;
        cfg_d      = 1'b0;
        ferr_d     = 1'b0;
        errc_d     = errc_q;
        commit     = 1'b0;
        commit_val = stage_q;
        stage_shift = (stage_q << 8) | {24'h0, bus_io.byte_data};

        // Deselect or timeout wins over any byte arriving in the same cycle.
        if (busy && (bus_io.spi_ss || expire)) begin
            state_d = StIdle;
            ferr_d  = 1'b1;
        end else if (bus_io.byte_valid && !bus_io.spi_ss) begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.byte_data == SYNC_BYTE) state_d = StCmd;
                end
                StCmd: begin
                    if (cmd_len(bus_io.byte_data) != 3'd0) begin
                        cmd_d   = bus_io.byte_data;
                        rem_d   = cmd_len(bus_io.byte_data);
`ifdef CMD_CHECKSUM_EN
                        xor_d   = bus_io.byte_data;
`endif
                        state_d = StPayload;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
                StPayload: begin
                    stage_d = stage_shift;
                    rem_d   = rem_q - 3'd1;
`ifdef CMD_CHECKSUM_EN
                    xor_d   = xor_q ^ bus_io.byte_data;
                    if (rem_q == 3'd1) state_d = StCheck;
`else
                    if (rem_q == 3'd1) begin
                        commit     = 1'b1;
                        commit_val = stage_shift;
                        state_d    = StIdle;
                    end
`endif
                end
`ifdef CMD_CHECKSUM_EN
                StCheck: begin
                    if (bus_io.byte_data == xor_q) commit = 1'b1;
                    else                           ferr_d = 1'b1;
                    state_d = StIdle;
                end
`endif
                default: state_d = StIdle;
            endcase
        end

        if (commit) begin
            cfg_d = 1'b1;
            case (cmd_q)
                CmdFreq:  freq_d  = commit_val;
                CmdPhase: phase_d = commit_val[15:0];
                CmdWave:  wave_d  = commit_val[1:0];
                CmdLed:   led_d   = commit_val[3:0];
                default:  ;
            endcase
        end

        if (ferr_d && (errc_q != 8'hFF)) errc_d = errc_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cmd_q   <= '0;
            rem_q   <= '0;
            stage_q <= '0;
`ifdef CMD_CHECKSUM_EN
            xor_q   <= '0;
`endif
            freq_q  <= '0;
            phase_q <= '0;
            wave_q  <= '0;
            led_q   <= '0;
            cfg_q   <= 1'b0;
            ferr_q  <= 1'b0;
            errc_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            rem_q   <= rem_d;
            stage_q <= stage_d;
`ifdef CMD_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
            freq_q  <= freq_d;
            phase_q <= phase_d;
            wave_q  <= wave_d;
            led_q   <= led_d;
            cfg_q   <= cfg_d;
            ferr_q  <= ferr_d;
            errc_q  <= errc_d;
        end
    end

    assign bus_io.freq_word  = freq_q;
    assign bus_io.phase_word = phase_q;
    assign bus_io.wave_sel   = wave_q;
    assign bus_io.led_groups = led_q;
    assign bus_io.cfg_update = cfg_q;
    assign bus_io.frame_err  = ferr_q;
    assign bus_io.err_cnt    = errc_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed plus randomized byte streams checked against a frame-buffer reference model.
module tb_spi_cmd_decoder;

    localparam int unsigned TimeoutCyc = 16;
`ifdef CMD_CHECKSUM_EN
    localparam int ChkLen = 1;
`else
    localparam int ChkLen = 0;
`endif

    logic clk = 1'b0;
    logic rst;

    spi_cmd_decoder_if bus ();

    spi_cmd_decoder #(
        .TIMEOUT_CYC(TimeoutCyc),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: buffer a whole frame, then judge it.
    bit          in_frame;
    logic [7:0]  frame[$];
    logic [31:0] m_freq;
    logic [15:0] m_phase;
    logic [1:0]  m_wave;
    logic [3:0]  m_led;
    int          m_errs;
    logic        m_cfg, m_ferr;

    function automatic int plen_of(input logic [7:0] c);
        case (c)
            8'h01:   return 4;
            8'h02:   return 2;
            8'h03:   return 1;
            8'h04:   return 1;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        in_frame = 0;
        frame.delete();
        m_freq = 0; m_phase = 0; m_wave = 0; m_led = 0;
        m_errs = 0; m_cfg = 0; m_ferr = 0;
    endtask

    task automatic model_err();
        m_ferr = 1;
        if (m_errs < 255) m_errs++;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int n;
        logic [7:0] x;
        logic [31:0] v;
        m_cfg = 0; m_ferr = 0;
        if (!in_frame) begin
            if (b == 8'hA5) begin
                in_frame = 1;
                frame.delete();
            end
        end else begin
            frame.push_back(b);
            n = plen_of(frame[0]);
            if (n < 0) begin
                model_err();
                in_frame = 0;
            end else if (frame.size() == 1 + n + ChkLen) begin
                x = 0; v = 0;
                for (int i = 0; i <= n; i++) x ^= frame[i];
                for (int i = 1; i <= n; i++) v = (v << 8) | 32'(frame[i]);
                in_frame = 0;
                if (ChkLen == 1 && frame[n+1] != x) begin
                    model_err();
                end else begin
                    m_cfg = 1;
                    case (frame[0])
                        8'h01:   m_freq  = v;
                        8'h02:   m_phase = v[15:0];
                        8'h03:   m_wave  = v[1:0];
                        8'h04:   m_led   = v[3:0];
                        default: ;
                    endcase
                end
            end
        end
    endtask

    task automatic model_abort();
        m_cfg = 0; m_ferr = 0;
        if (in_frame) model_err();
        in_frame = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " cfg_update"}, 32'(bus.cfg_update), 32'(m_cfg));
        chk({tag, " frame_err"},  32'(bus.frame_err),  32'(m_ferr));
        chk({tag, " freq_word"},  bus.freq_word,       m_freq);
        chk({tag, " phase_word"}, 32'(bus.phase_word), 32'(m_phase));
        chk({tag, " wave_sel"},   32'(bus.wave_sel),   32'(m_wave));
        chk({tag, " led_groups"}, 32'(bus.led_groups), 32'(m_led));
        chk({tag, " err_cnt"},    32'(bus.err_cnt),    32'(m_errs));
    endtask

    task automatic send_byte(input logic [7:0] b, input string tag);
        int gap;
        gap = int'($urandom_range(2, 0));
        repeat (gap) begin
            @(negedge clk);
            chk({tag, " idle cfg_update"}, 32'(bus.cfg_update), 32'd0);
            chk({tag, " idle frame_err"},  32'(bus.frame_err),  32'd0);
        end
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        model_byte(b);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        check_all(tag);
    endtask

    task automatic send_seq(input logic [7:0] seq[$], input string tag);
        foreach (seq[i]) send_byte(seq[i], tag);
    endtask

    // Raise spi_ss for two cycles, optionally with a byte strobe on the first.
    task automatic ss_abort(input bit with_byte, input logic [7:0] b, input string tag);
        @(negedge clk);
        bus.spi_ss     = 1'b1;
        bus.byte_valid = with_byte;
        bus.byte_data  = b;
        model_abort();
        @(negedge clk);
        bus.byte_valid = 1'b0;
        check_all(tag);
        @(negedge clk);
        model_abort();
        check_all({tag, " ss idle"});
        bus.spi_ss = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        bus.byte_valid = 1'b0;
        bus.spi_ss     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all(tag);
    endtask

    initial begin
        logic [7:0] seq[$];
        logic [7:0] cmd, pb, x;
        int n;

        rst = 1'b1;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.spi_ss     = 1'b0;
        model_reset();
        do_reset("reset");

        seq = {8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        send_seq(seq, "freq");
        chk("freq value", bus.freq_word, 32'h1234_5678);

        seq = {8'h00, 8'hFF, 8'hA5, 8'h02, 8'h80, 8'h00, 8'h82};
        send_seq(seq, "phase");
        chk("phase value", 32'(bus.phase_word), 32'h8000);

        seq = {8'hA5, 8'h03, 8'h02, 8'hFF};
        send_seq(seq, "badchk");

        seq = {8'hA5, 8'h7E};
        send_seq(seq, "unkcmd");
        seq = {8'hA5, 8'h04, 8'h0A, 8'h0E};
        send_seq(seq, "led");
        chk("led value", 32'(bus.led_groups), 32'hA);

        seq = {8'hA5, 8'h01, 8'hAB};
        send_seq(seq, "abort pre");
        ss_abort(1'b1, 8'hCD, "ss abort");
        seq = {8'hEF, 8'h01, 8'h23};
        send_seq(seq, "after abort");
        chk("freq kept", bus.freq_word, 32'h1234_5678);

        seq = {8'hA5, 8'h01};
        send_seq(seq, "tmo pre");
        repeat (TimeoutCyc - 1) @(negedge clk);
        chk("tmo early frame_err", 32'(bus.frame_err), 32'd0);
        @(negedge clk);
        model_abort();
        check_all("timeout");
        seq = {8'hA5, 8'h04, 8'h05, 8'h01};
        send_seq(seq, "after tmo");

        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(3, 0) == 0) send_byte(8'($urandom), "rnd junk");
            cmd = ($urandom_range(4, 0) == 0) ? 8'($urandom) : 8'($urandom_range(4, 1));
            send_byte(8'hA5, "rnd sync");
            send_byte(cmd, "rnd cmd");
            n = plen_of(cmd);
            x = cmd;
            for (int i = 0; i < n; i++) begin
                pb = 8'($urandom);
                x ^= pb;
                send_byte(pb, "rnd payload");
            end
            if (n > 0) begin
                if ($urandom_range(3, 0) == 0) x ^= 8'($urandom_range(255, 1));
                send_byte(x, "rnd chk");
            end
        end
        ss_abort(1'b0, 8'h00, "rnd resync");

        for (int i = 0; i < 300; i++) begin
            send_byte(8'hA5, "sat sync");
            send_byte(8'h7E, "sat cmd");
        end
        chk("err_cnt saturated", 32'(bus.err_cnt), 32'hFF);

        seq = {8'hA5, 8'h01, 8'h11};
        send_seq(seq, "rst pre");
        do_reset("mid reset");
        seq = {8'h22, 8'h33, 8'h44, 8'h55};
        send_seq(seq, "post reset");
        seq = {8'hA5, 8'h04, 8'h0C, 8'h08};
        send_seq(seq, "post reset led");
        chk("post reset led value", 32'(bus.led_groups), 32'hC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
Consumes bytes from the SPI slave receiver and parses framed commands into DDS and LED control registers. Downstream of the SPI byte receiver; its outputs drive the DDS phase accumulator and the LED_Groups/RGB outputs in top. Frames are validated by checksum, length and timeout. Registers update atomically, only when a frame passes all checks.

Parameters:
- TIMEOUT_CYC, 100000: clk cycles with no byte in a non-IDLE state before the frame is aborted.
- SYNC_BYTE, 8'hA5: frame header byte.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- byte_valid  in  1  one-cycle strobe from SPI receiver
- byte_data  in  8  received byte, valid when byte_valid=1
- spi_ss  in  1  SPI chip select, active low, already synchronised to clk
- freq_word  out  32  DDS frequency tuning word
- phase_word  out  16  DDS phase offset
- wave_sel  out  2  waveform select (0 sine, 1 square, 2 triangle, 3 saw)
- led_groups  out  4  LED group pattern
- cfg_update  out  1  one-cycle pulse when any register commits
- frame_err  out  1  one-cycle pulse on any rejected or aborted frame
- err_cnt  out  8  saturating error counter

Behaviour:
- Reset values: all outputs 0, state IDLE, staging register 0, timeout counter 0.
- Frame format: SYNC, CMD, payload (MSB first), CHK. CHK is the XOR of CMD and all payload bytes.
- CMD values and payload lengths:
  - 8'h01: freq_word, 4 bytes.
  - 8'h02: phase_word, 2 bytes.
  - 8'h03: wave_sel = payload[1:0], 1 byte.
  - 8'h04: led_groups = payload[3:0], 1 byte.
- IDLE: a byte equal to SYNC moves to CMD. Any other byte is silently ignored, with no error.
- CMD: a known CMD latches the length, seeds the running XOR with CMD, and moves to PAYLOAD. An unknown CMD pulses frame_err and returns to IDLE.
- PAYLOAD: each byte shifts into a 32-bit staging register (left shift) and is XORed into the running XOR. The remaining-byte counter decrements. After the last payload byte, move to CHECK.
- CHECK, match: the target register is loaded from staging. cfg_update pulses in the cycle after the CHK strobe, and the new value is visible in that same cycle (latency 1 clk). Return to IDLE.
- CHECK, mismatch: frame_err pulses in the cycle after the strobe. No register changes. Return to IDLE.
- Abort on spi_ss: spi_ss=1 in any non-IDLE state aborts the frame with a frame_err pulse and returns to IDLE. spi_ss=1 in IDLE is not an error.
- Abort on timeout: the timeout counter runs only in non-IDLE states and clears on each byte_valid. Reaching TIMEOUT_CYC-1 aborts with a frame_err pulse and returns to IDLE.
- Simultaneous byte_valid and spi_ss=1: the abort wins and the byte is discarded.
- frame_err and cfg_update never assert in the same cycle.
- err_cnt increments on each frame_err pulse and saturates at 8'hFF. It is cleared only by rst.
- rst mid-frame returns everything to reset values, including committed registers.

Optional Feature:
- CMD_CHECKSUM_EN defined: CHK byte required and checked, as above.
- CMD_CHECKSUM_EN undefined: frames end after the payload. Commit happens in the cycle after the last payload strobe, the CHECK state and XOR logic are absent, and mismatch errors cannot occur.

Decomposition:
- Package spi_cmd_pkg holds:
  - the state enum (IDLE, CMD, PAYLOAD, CHECK);
  - the CMD code constants;
  - a length lookup function for CMD → payload byte count;
  - SYNC_BYTE default.
- One natural sub-module, spi_cmd_timeout: the loadable, clearable timeout counter with an expiry strobe.

Test Plan:
- Frequency write: feed A5 01 12 34 56 78 09 → freq_word=32'h12345678, cfg_update pulses once 1 clk after the 09 strobe, frame_err stays 0.
- Phase write preceded by junk: feed 00 FF A5 02 80 00 82 → phase_word=16'h8000, no frame_err for the leading 00 FF.
- Bad checksum: feed A5 03 02 FF → wave_sel unchanged at 0, one frame_err pulse, err_cnt=1.
- Unknown CMD: feed A5 7E → frame_err pulse. A following valid frame A5 04 0A 0E → led_groups=4'hA.
- spi_ss abort: feed A5 01 12, then raise spi_ss → frame_err pulse, freq_word unchanged. Also drive byte_valid on the same cycle spi_ss rises and check the byte is dropped.
- Timeout and saturation: with TIMEOUT_CYC=16, feed A5 01 and then stall 16 clks → frame_err and return to IDLE. Force 300 errors → err_cnt=8'hFF.
